task_delay_scheduler: RTL
=========================

# task_delay_scheduler

Synthesizable concurrent delay-task scheduler: the hardware counterpart of a `fork ... join_none` launcher with `disable fork`. It accepts task launches carrying a delay and an ID, runs up to NUM_SLOTS countdowns in parallel, and emits each task's completion record in expiry order. It sits directly upstream of the completion consumer/display stage, which takes records over a valid/ready port. An optional kill input aborts all in-flight tasks.

## Interface
- NUM_SLOTS, 4, concurrent task slots (2..16)
- DELAY_W, 8, delay field width, in cycles
- ID_W, 4, task ID width
- TIME_W, 16, timestamp width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- launch_valid  in  1  launch request
- launch_ready  out  1  a slot is free and kill is not asserted
- launch_delay  in  DELAY_W  countdown in cycles
- launch_id  in  ID_W  task number
- kill  in  1  abort all in-flight slots (see Configuration)
- done_valid  out  1  completion record valid
- done_ready  in  1  consumer accepts record
- done_id  out  ID_W  completed task ID
- done_delay  out  DELAY_W  delay the task was launched with
- done_time  out  TIME_W  timestamp at record load
- busy  out  1  any slot occupied, or done_valid high
- active_count  out  $clog2(NUM_SLOTS+1)  occupied slots

## Operation
- Each slot holds: occupied flag, remaining count, ID, delay.
- Launch: on a clk edge with launch_valid && launch_ready, the lowest-index free slot is loaded with remaining=launch_delay.
- Free mask is sampled before the edge. A slot freed on an edge is reusable from the next edge.
- Countdown: an occupied slot with remaining>0 decrements by 1 per edge. A slot with remaining==0 is expired and holds at 0 until drained.
- Drain: when !done_valid || done_ready, the lowest-index expired slot is moved into the output register and freed on the same edge.
- done_time = timestamp value before that edge.
- Output register: done_valid and all done_* fields hold stable until accepted.
- Timestamp: free-running counter, increments every edge, wraps modulo 2^TIME_W.
- Kill (when compiled in): on an edge with kill=1, every slot is freed and any launch is blocked because launch_ready=0. The output register is unaffected, so an already-completed record is still delivered.
- Reset: all slots free, timestamp=0, done_valid=0, done_* =0, launch_ready=1, busy=0, active_count=0.
- Reset mid-operation discards all slots and any pending record immediately (asynchronous).

## Timing
- Uncontended latency: launch accepted at edge T with delay D gives done_valid high after edge T+D+1.
  - D=0 gives T+1.
- Contention (several expired slots, or output stalled): each extra wait cycle adds 1 to latency. Countdowns of other slots are unaffected.
- Throughput: one launch and one completion per cycle maximum, simultaneously.
- launch_ready is combinational from slot occupancy and kill. It does not depend on launch_valid.
- active_count and busy reflect registered state only (post-edge).
- Full: NUM_SLOTS occupied forces launch_ready=0, even if a slot drains that cycle.

## Configuration
- TASK_SCHED_KILL_EN defined: kill behaves as described in Operation.
- TASK_SCHED_KILL_EN undefined:
  - kill is ignored; the port remains for a stable interface.
  - launch_ready depends on occupancy only.
  - Tasks always run to completion.

## Test plan
- Three launches on consecutive edges T, T+1, T+2 with (D=30,id=1), (D=20,id=2), (D=10,id=3), done_ready=1 -> completions in order id3, id2, id1 at edges T+13, T+22, T+31.
- Two slots expiring on the same edge, done_ready=0 for 5 cycles -> lowest slot delivered first with fields stable during the stall. Second record follows one cycle after acceptance.
- Fill all 4 slots (D=50) -> launch_ready=0 and active_count=4. After first drain, launch_ready=1 on the next cycle.
- D=0 launch with idle output -> done_valid one edge later, done_delay=0. Back-to-back D=0 launches give one completion per cycle.
- Two slots running plus one pending record, kill pulsed 1 cycle (KILL_EN):
  - Pending record is still delivered.
  - Both running slots never complete; active_count=0; launch blocked during kill.
  - Without the macro, both complete.
- Async rst asserted mid-countdown between edges -> outputs go to reset values immediately. No stale completion after release. done_time restarts from 0.

Source files
------------

// File: rtl/task_delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : task_delay_scheduler
// Brief    : Concurrent delay-task scheduler. Accepts task launches carrying
//            a delay and an ID, counts them down in parallel slots and emits
//            completion records in expiry order over a valid/ready port.
// Options  : TASK_SCHED_KILL_EN - when defined, the kill input frees every
//            slot and blocks launches. When undefined, kill is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module task_delay_scheduler #(
   parameter int NUM_SLOTS = 4,
   parameter int DELAY_W   = 8,
   parameter int ID_W      = 4,
   parameter int TIME_W    = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             launch_valid,
   output logic                             launch_ready,
   input  logic [DELAY_W-1:0]               launch_delay,
   input  logic [ID_W-1:0]                  launch_id,
   input  logic                             kill,
   output logic                             done_valid,
   input  logic                             done_ready,
   output logic [ID_W-1:0]                  done_id,
   output logic [DELAY_W-1:0]               done_delay,
   output logic [TIME_W-1:0]                done_time,
   output logic                             busy,
   output logic [$clog2(NUM_SLOTS+1)-1:0]   active_count
);

   localparam int C_CNT_W  = $clog2(NUM_SLOTS + 1);
   localparam int C_SLOT_W = $clog2(NUM_SLOTS);

   // Slot storage
   logic [NUM_SLOTS-1:0] r_occ;
   logic [DELAY_W-1:0]   r_rem [NUM_SLOTS];
   logic [ID_W-1:0]      r_id  [NUM_SLOTS];
   logic [DELAY_W-1:0]   r_dly [NUM_SLOTS];

   // Free-running timestamp and output register
   logic [TIME_W-1:0]    r_time;
   logic                 r_done_valid;
   logic [ID_W-1:0]      r_done_id;
   logic [DELAY_W-1:0]   r_done_delay;
   logic [TIME_W-1:0]    r_done_time;

   // Combinational control
   logic                 w_kill;
   logic [NUM_SLOTS-1:0] w_expired;
   logic [NUM_SLOTS-1:0] w_launch_oh;
   logic [NUM_SLOTS-1:0] w_drain_oh;
   logic [C_SLOT_W-1:0]  w_drain_idx;
   logic                 w_launch_fire;
   logic                 w_drain_fire;
   logic [C_CNT_W-1:0]   w_count;

`ifdef TASK_SCHED_KILL_EN
   assign w_kill = kill;
`else
   // kill is kept on the port for a stable interface but has no effect
   logic w_unused_kill;
   assign w_unused_kill = kill;
   assign w_kill        = 1'b0;
`endif

   // A slot is expired once occupied with nothing left to count
   generate
      for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
         assign w_expired[g] = r_occ[g] && (r_rem[g] == '0);
      end
   endgenerate

   // Lowest-index free slot receives the next launch
   always_comb begin
      w_launch_oh = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!r_occ[i]) begin
            w_launch_oh    = '0;
            w_launch_oh[i] = 1'b1;
         end
      end
   end

   // Lowest-index expired slot is the next one moved to the output
   always_comb begin
      w_drain_oh  = '0;
      w_drain_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (w_expired[i]) begin
            w_drain_oh    = '0;
            w_drain_oh[i] = 1'b1;
            w_drain_idx   = C_SLOT_W'(i);
         end
      end
   end

   // Occupancy count of registered slot state
   always_comb begin
      w_count = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         w_count = w_count + C_CNT_W'(r_occ[i]);
      end
   end

   // Full uses registered occupancy only, so a same-cycle drain does not help
   assign launch_ready  = (|(~r_occ)) && !w_kill;
   assign w_launch_fire = launch_valid && launch_ready;
   // Killed slots are not drained; the output register only sees the handshake
   assign w_drain_fire  = (!r_done_valid || done_ready) && (|w_expired) && !w_kill;

   // Slot load, countdown, drain-free and kill
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_rem[i] <= '0;
            r_id[i]  <= '0;
            r_dly[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_kill) begin
               r_occ[i] <= 1'b0;
            end else if (w_launch_fire && w_launch_oh[i]) begin
               r_occ[i] <= 1'b1;
               r_rem[i] <= launch_delay;
               r_id[i]  <= launch_id;
               r_dly[i] <= launch_delay;
            end else if (w_drain_fire && w_drain_oh[i]) begin
               r_occ[i] <= 1'b0;
            end else if (r_occ[i] && (r_rem[i] != '0)) begin
               r_rem[i] <= r_rem[i] - DELAY_W'(1);
            end
         end
      end
   end

   // Timestamp advances every edge and wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_time <= '0;
      end else begin
         r_time <= r_time + TIME_W'(1);
      end
   end

   // Output record register: load on drain, clear on acceptance, else hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done_valid <= 1'b0;
         r_done_id    <= '0;
         r_done_delay <= '0;
         r_done_time  <= '0;
      end else if (w_drain_fire) begin
         r_done_valid <= 1'b1;
         r_done_id    <= r_id[w_drain_idx];
         r_done_delay <= r_dly[w_drain_idx];
         r_done_time  <= r_time;
      end else if (done_ready) begin
         r_done_valid <= 1'b0;
      end
   end

   assign done_valid   = r_done_valid;
   assign done_id      = r_done_id;
   assign done_delay   = r_done_delay;
   assign done_time    = r_done_time;
   assign busy         = (|r_occ) || r_done_valid;
   assign active_count = w_count;

endmodule
`default_nettype wire
